// File: rtl/store_arbiter.sv
// Multi-channel store buffer: one FIFO per channel, round-robin drained into a single
// registered output stage. Define STORE_ARB_DROP_CNT_EN to add the saturating drop_cnt output.
module store_arbiter #(
  parameter int N     = 32,
  parameter int CH    = 4,
  parameter int DEPTH = 4,
  localparam int SW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   store,
  input  logic [CH*N-1:0] data,
  output logic [CH-1:0]   full,
  input  logic            ready,
  output logic            write,
  output logic [N-1:0]    wdata,
  output logic [SW-1:0]   wsel
`ifdef STORE_ARB_DROP_CNT_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CH-1:0] nonempty;
  logic [CH-1:0] push;
  logic [CH-1:0] pop;
  logic [N-1:0]  head [CH];

  logic          free;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] last_grant_reg;
  logic          write_reg;
  logic [N-1:0]  wdata_reg;
  logic [SW-1:0] wsel_reg;

  assign free = !write_reg || ready;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [N-1:0]  mem [DEPTH];
      logic [PW-1:0] wptr_reg;
      logic [PW-1:0] rptr_reg;
      logic [CW-1:0] count_reg;

      // Push is qualified on the pre-edge count, so a full channel drops even when popped.
      assign full[gi]     = (count_reg == CW'(DEPTH));
      assign nonempty[gi] = (count_reg != '0);
      assign push[gi]     = store[gi] && !full[gi];
      assign pop[gi]      = free && grant_valid && (grant_idx == SW'(gi));
      assign head[gi]     = mem[rptr_reg];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wptr_reg] <= data[gi*N +: N];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (push[gi]) begin
            wptr_reg <= wptr_reg + PW'(1);
          end
          if (pop[gi]) begin
            rptr_reg <= rptr_reg + PW'(1);
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Scan channels starting just after the last grant, wrapping at CH-1.
  always_comb begin
    logic [SW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = last_grant_reg;
    for (int k = 0; k < CH; k++) begin
      cand = (cand == SW'(CH - 1)) ? '0 : cand + SW'(1);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_reg      <= 1'b0;
      wdata_reg      <= '0;
      wsel_reg       <= '0;
      last_grant_reg <= SW'(CH - 1);
    end else if (free) begin
      if (grant_valid) begin
        write_reg      <= 1'b1;
        wdata_reg      <= head[grant_idx];
        wsel_reg       <= grant_idx;
        last_grant_reg <= grant_idx;
      end else begin
        write_reg <= 1'b0;
      end
    end
  end

  assign write = write_reg;
  assign wdata = wdata_reg;
  assign wsel  = wsel_reg;

`ifdef STORE_ARB_DROP_CNT_EN
  logic [CH-1:0] drop;
  logic [15:0]   drop_cnt_reg;
  logic [16:0]   drop_sum;

  assign drop = store & full;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_reg};
    for (int i = 0; i < CH; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_store_arbiter.sv
// Randomized bench for store_arbiter: a queue-based model tracks every buffered word and
// the output stage; DUT outputs are compared one clock-step at a time.
module tb_store_arbiter;
  localparam int N     = 32;
  localparam int CH    = 4;
  localparam int DEPTH = 4;

  logic            clk;
  logic            reset;
  logic [CH-1:0]   store;
  logic [CH*N-1:0] data;
  logic [CH-1:0]   full;
  logic            ready;
  logic            write;
  logic [N-1:0]    wdata;
  logic [1:0]      wsel;
`ifdef STORE_ARB_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  store_arbiter #(.N(N), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .store(store),
    .data(data),
    .full(full),
    .ready(ready),
    .write(write),
    .wdata(wdata),
    .wsel(wsel)
`ifdef STORE_ARB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference state: buffered words per channel plus the presented word.
  logic [N-1:0] q [CH][$];
  logic         exp_write;
  logic [N-1:0] exp_wdata;
  int           exp_wsel;
  int           exp_last;
  int           exp_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) q[i].delete();
    exp_write = 1'b0;
    exp_wdata = '0;
    exp_wsel  = 0;
    exp_last  = CH - 1;
    exp_drop  = 0;
  endtask

  task automatic model_step(input logic [CH-1:0] st, input logic [CH*N-1:0] d, input logic rd);
    int sz [CH];
    bit found;
    int c;
    for (int i = 0; i < CH; i++) sz[i] = q[i].size();
    if (!exp_write || rd) begin
      found = 1'b0;
      for (int k = 1; k <= CH; k++) begin
        c = (exp_last + k) % CH;
        if (!found && sz[c] > 0) begin
          found     = 1'b1;
          exp_wdata = q[c].pop_front();
          exp_wsel  = c;
          exp_last  = c;
        end
      end
      exp_write = found;
    end
    for (int i = 0; i < CH; i++) begin
      if (st[i]) begin
        if (sz[i] < DEPTH) q[i].push_back(d[i*N +: N]);
        else if (exp_drop < 16'hFFFF) exp_drop++;
      end
    end
  endtask

  task automatic cycle(input logic [CH-1:0] st, input logic [CH*N-1:0] d, input logic rd);
    logic [CH-1:0] exp_full;
    store = st;
    data  = d;
    ready = rd;
    model_step(st, d, rd);
    @(posedge clk);
    #1;
    cyc++;
    check("write", {63'd0, write}, {63'd0, exp_write});
    if (exp_write) begin
      check("wdata", {32'd0, wdata}, {32'd0, exp_wdata});
      check("wsel", {62'd0, wsel}, 64'(exp_wsel));
      $display("txn cyc=%0d ch=%0d data=%h ready_next=?", cyc, exp_wsel, exp_wdata);
    end
    for (int i = 0; i < CH; i++) exp_full[i] = (q[i].size() == DEPTH);
    check("full", {60'd0, full}, {60'd0, exp_full});
`ifdef STORE_ARB_DROP_CNT_EN
    check("drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
`endif
  endtask

  function automatic logic [CH*N-1:0] rand_data();
    logic [CH*N-1:0] d;
    for (int i = 0; i < CH; i++) d[i*N +: N] = $urandom;
    return d;
  endfunction

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) cycle('0, '0, rd);
  endtask

  initial begin
    logic [CH*N-1:0] d;
    logic            rd;
    int              mode;

    store = '0;
    data  = '0;
    ready = 1'b0;
    reset = 1'b0;
    model_reset();
    #2;
    check("rst_write", {63'd0, write}, 64'd0);
    check("rst_wdata", {32'd0, wdata}, 64'd0);
    check("rst_wsel", {62'd0, wsel}, 64'd0);
    check("rst_full", {60'd0, full}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single store on channel 2: visible one edge later, gone the edge after.
    d = '0;
    d[2*N +: N] = 32'hA5A5A5A5;
    cycle(4'b0100, d, 1'b1);
    check("lat_nobypass", {63'd0, write}, 64'd0);
    cycle('0, '0, 1'b1);
    check("lat_write", {63'd0, write}, 64'd1);
    check("lat_wsel", {62'd0, wsel}, 64'd2);
    check("lat_wdata", {32'd0, wdata}, 64'hA5A5A5A5);
    cycle('0, '0, 1'b1);
    check("lat_drain", {63'd0, write}, 64'd0);

    // All channels store together, then drain in round-robin order.
    for (int i = 0; i < CH; i++) d[i*N +: N] = 32'h100 + i;
    cycle('1, d, 1'b1);
    idle(6, 1'b1);

    // Overfill channel 1 while the sink stalls, then release.
    for (int i = 1; i <= 7; i++) begin
      d = '0;
      d[1*N +: N] = i;
      cycle(4'b0010, d, 1'b0);
    end
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Full channel 0 stored into on the same edge it is popped.
    for (int i = 0; i < 6; i++) begin
      d = '0;
      d[0 +: N] = 32'h200 + i;
      cycle(4'b0001, d, 1'b0);
    end
    d = '0;
    d[0 +: N] = 32'h2FF;
    cycle(4'b0001, d, 1'b1);
    idle(8, 1'b1);

    // Stall with word presented while other channels keep storing.
    cycle(4'b1000, rand_data(), 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0110, rand_data(), 1'b0);
    idle(10, 1'b1);

    // Reset between edges with words buffered and one presented.
    cycle(4'b0111, rand_data(), 1'b0);
    cycle(4'b0001, rand_data(), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_write", {63'd0, write}, 64'd0);
    check("midrst_full", {60'd0, full}, 64'd0);
    check("midrst_wdata", {32'd0, wdata}, 64'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", {63'd0, write}, 64'd0);
    reset = 1'b1;
    idle(5, 1'b1);

    // Randomized traffic with varying sink back-pressure.
    for (int n = 0; n < 1500; n++) begin
      mode = (n / 100) % 3;
      case (mode)
        0:       rd = 1'b1;
        1:       rd = ($urandom_range(0, 1) == 0);
        default: rd = ($urandom_range(0, 7) == 0);
      endcase
      cycle(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), rand_data(), rd);
    end
    idle(30, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
